// File: rtl/voq_rr_scheduler.sv
// Per-destination VOQ read scheduler: round-robin packet grant, credit-paced pops,
// and the registered read-mux select for one output port of the shared-cache switch.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif

module voq_rr_scheduler #(
    parameter int PORT_NUB   = `PORT_NUB_TOTAL,
    parameter int DEST       = 0,
    parameter int CREDIT_MAX = 16,
    parameter int WIDTH_SEL  = $clog2(PORT_NUB),
    parameter int WIDTH_CRD  = $clog2(CREDIT_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PORT_NUB-1:0]  req,
    input  logic                 rd_valid,
    input  logic                 rd_last,
    input  logic                 credit_ret,
    output logic [PORT_NUB-1:0]  rd_en,
    output logic [WIDTH_SEL-1:0] sel,
    output logic                 grant_valid,
    output logic [WIDTH_CRD-1:0] credit_cnt,
    output logic                 credit_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [WIDTH_SEL-1:0] RR_START = WIDTH_SEL'(DEST % PORT_NUB);
    localparam logic [WIDTH_SEL-1:0] LAST_IDX = WIDTH_SEL'(PORT_NUB - 1);
    localparam logic [WIDTH_SEL:0]   NUB_EXT  = (WIDTH_SEL + 1)'(PORT_NUB);
    localparam logic [WIDTH_CRD-1:0] CRD_MAX  = WIDTH_CRD'(CREDIT_MAX);

    state_t               state_q;
    logic [WIDTH_SEL-1:0] sel_q;
    logic [WIDTH_SEL-1:0] rr_ptr_q;
    logic                 grant_valid_q;
    logic [WIDTH_CRD-1:0] credit_q;
    logic [WIDTH_CRD-1:0] credit_d;
    logic                 credit_err_q;
    logic                 credit_err_d;

    logic [WIDTH_SEL-1:0] cand_idx [PORT_NUB];
    logic                 pick_found;
    logic [WIDTH_SEL-1:0] pick_idx;
    logic                 beat;
    logic [WIDTH_SEL-1:0] sel_inc;

    genvar gi;

    // cand_idx[k] is the VOQ index k positions above the pointer, wrapped.
    generate
        for (gi = 0; gi < PORT_NUB; gi++) begin : g_cand
            logic [WIDTH_SEL:0] sum;
            assign sum          = {1'b0, rr_ptr_q} + (WIDTH_SEL + 1)'(gi);
            assign cand_idx[gi] = (sum >= NUB_EXT) ? WIDTH_SEL'(sum - NUB_EXT)
                                                   : sum[WIDTH_SEL-1:0];
        end
    endgenerate

    // Scan from the far end down so the candidate nearest the pointer wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = PORT_NUB - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    generate
        for (gi = 0; gi < PORT_NUB; gi++) begin : g_rd_en
            assign rd_en[gi] = (state_q == XFER) && (sel_q == WIDTH_SEL'(gi));
        end
    endgenerate

    assign beat    = rd_en[sel_q] & rd_valid;
    assign sel_inc = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;

    // A beat and a returned credit in the same cycle cancel out.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        case ({beat, credit_ret})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CRD_MAX) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d = credit_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= RR_START;
            credit_q      <= CRD_MAX;
            credit_err_q  <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            case (state_q)
                IDLE: begin
                    if (pick_found && (credit_q != '0)) begin
                        sel_q         <= pick_idx;
                        grant_valid_q <= 1'b1;
                        state_q       <= XFER;
                    end
                end
                XFER: begin
                    // The pointer only moves when a packet completes.
                    if (beat && rd_last) begin
                        rr_ptr_q      <= sel_inc;
                        grant_valid_q <= 1'b0;
                        state_q       <= IDLE;
                    end else if (beat && (credit_d == '0)) begin
                        state_q <= STALL;
                    end
                end
                STALL: begin
                    if (credit_q != '0) begin
                        state_q <= XFER;
                    end
                end
                default: begin
                    grant_valid_q <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign sel         = sel_q;
    assign grant_valid = grant_valid_q;
    assign credit_cnt  = credit_q;
    assign credit_err  = credit_err_q;

    a_rd_en_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rd_en));
    a_grant_state:  assert property (@(posedge clk) disable iff (!rst_n)
                                     grant_valid == (state_q != IDLE));
    a_credit_range: assert property (@(posedge clk) disable iff (!rst_n) credit_q <= CRD_MAX);

endmodule

// File: tb/tb_voq_rr_scheduler.sv
// Bench for voq_rr_scheduler (8 ports, DEST=3, 16 credits): vector table driven
// through a one-deep scoreboard, plus hand-written asynchronous reset sequences.
module tb_voq_rr_scheduler;

    localparam int N    = 8;
    localparam int DEST = 3;
    localparam int CMAX = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       rd_valid = 1'b0;
    logic       rd_last = 1'b0;
    logic       credit_ret = 1'b0;
    logic [7:0] rd_en;
    logic [2:0] sel;
    logic       grant_valid;
    logic [4:0] credit_cnt;
    logic       credit_err;

    voq_rr_scheduler #(
        .PORT_NUB   (N),
        .DEST       (DEST),
        .CREDIT_MAX (CMAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .rd_valid    (rd_valid),
        .rd_last     (rd_last),
        .credit_ret  (credit_ret),
        .rd_en       (rd_en),
        .sel         (sel),
        .grant_valid (grant_valid),
        .credit_cnt  (credit_cnt),
        .credit_err  (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       rv;
        logic       rl;
        logic       cr;
        logic       gv;
        logic [2:0] sel;
        logic [7:0] rd_en;
        logic [4:0] crd;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_a;

    function automatic vec_t mk(input logic [7:0] rq, input logic rv, input logic rl,
                                input logic cr, input logic gv, input logic [2:0] s,
                                input logic [7:0] re, input logic [4:0] c, input logic e);
        vec_t v;
        v.req = rq; v.rv = rv; v.rl = rl; v.cr = cr;
        v.gv = gv; v.sel = s; v.rd_en = re; v.crd = c; v.err = e;
        return v;
    endfunction

    function automatic void add(input logic [7:0] rq, input logic rv, input logic rl,
                                input logic cr, input logic gv, input logic [2:0] s,
                                input logic [7:0] re, input logic [4:0] c, input logic e);
        vecs.push_back(mk(rq, rv, rl, cr, gv, s, re, c, e));
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_grant_valid", idx, 32'(grant_valid), 32'd0);
        chk("rst_sel",         idx, 32'(sel),         32'd0);
        chk("rst_rd_en",       idx, 32'(rd_en),       32'd0);
        chk("rst_credit",      idx, 32'(credit_cnt),  32'(CMAX));
        chk("rst_credit_err",  idx, 32'(credit_err),  32'd0);
    endtask

    // Called at a falling edge: drive, queue the expectation, compare after the next edge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        req        = v.req;
        rd_valid   = v.rv;
        rd_last    = v.rl;
        credit_ret = v.cr;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("grant_valid", idx, 32'(grant_valid), 32'(e.gv));
        chk("sel",         idx, 32'(sel),         32'(e.sel));
        chk("rd_en",       idx, 32'(rd_en),       32'(e.rd_en));
        chk("credit_cnt",  idx, 32'(credit_cnt),  32'(e.crd));
        chk("credit_err",  idx, 32'(credit_err),  32'(e.err));
        $display("step %0d: req=%02h rv=%0b rl=%0b cr=%0b -> gv=%0b sel=%0d rd_en=%02h crd=%0d err=%0b",
                 idx, v.req, v.rv, v.rl, v.cr, grant_valid, sel, rd_en, credit_cnt, credit_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Round-robin sweep with 1-beat packets, starting at DEST.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] s;
            s = 3'((DEST + i) % N);
            add(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, s, 8'(1 << s), 5'(CMAX - i), 1'b0);
            add(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, s, 8'h00, 5'(CMAX - 1 - i), 1'b0);
        end
        n_a = vecs.size();

        // Two requesters, 3-beat packets.
        add(8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 5'd16, 1'b0);
        add(8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 5'd15, 1'b0);
        add(8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 5'd14, 1'b0);
        add(8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 5'd13, 1'b0);
        add(8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 8'h04, 5'd13, 1'b0);
        add(8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 5'd12, 1'b0);
        add(8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 5'd11, 1'b0);
        add(8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 5'd10, 1'b0);
        add(8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 5'd10, 1'b0);
        add(8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 5'd9,  1'b0);
        add(8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 5'd8,  1'b0);
        add(8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 5'd7,  1'b0);

        // Long packet on VOQ 1 runs credit to zero; req drops mid-packet.
        add(8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 5'd7, 1'b0);
        for (int b = 1; b <= 7; b++) begin
            add((b <= 2) ? 8'h02 : 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1,
                (b < 7) ? 8'h02 : 8'h00, 5'(7 - b), 1'b0);
        end
        add(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 5'd0, 1'b0);
        add(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'h00, 5'd1, 1'b0);
        add(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 5'd1, 1'b0);
        add(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 5'd0, 1'b0);
        add(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'h00, 5'd1, 1'b0);
        add(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 5'd1, 1'b0);
        add(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 5'd0, 1'b0);

        // No grant with zero credit, then grant once a credit is back.
        add(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 5'd0, 1'b0);
        add(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00, 5'd1, 1'b0);
        add(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 5'd1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            add(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04, 5'd1, 1'b0);
        end
        add(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 8'h00, 5'd1, 1'b0);

        // Refill to the maximum, then overflow sets the sticky error.
        for (int k = 2; k <= CMAX; k++) begin
            add(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 5'(k), 1'b0);
        end
        add(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 5'd16, 1'b1);
        add(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 5'd16, 1'b1);
        add(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 5'd16, 1'b1);

        // Move the pointer away from DEST, then leave a packet in flight.
        add(8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 5'd16, 1'b1);
        add(8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 5'd15, 1'b1);
        add(8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 8'h00, 5'd14, 1'b1);
        add(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 5'd14, 1'b1);
        add(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 5'd13, 1'b1);

        // Power-on reset.
        repeat (2) @(negedge clk);
        chk_reset(-1);
        rst_n = 1'b1;

        for (int i = 0; i < n_a; i++) begin
            apply(vecs[i], i);
        end

        // Synchronous-position reset between sections restores full credit.
        #2 rst_n = 1'b0;
        #1 chk_reset(-2);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = n_a; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Asynchronous reset mid-packet: outputs clear without a clock edge.
        req = 8'hFF; rd_valid = 1'b1; rd_last = 1'b1; credit_ret = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset(-3);
        @(negedge clk);
        chk_reset(-4);
        rst_n = 1'b1;

        // Next grant starts from DEST again.
        apply(mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 5'd16, 1'b0), 1000);
        apply(mk(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 5'd15, 1'b0), 1001);
        apply(mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 5'd15, 1'b0), 1002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
